// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer: FSM states,
// command codes, status byte layout and the pending MISO-load kinds.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR      = 3'd3,
    ST_RD      = 3'd4,
    ST_FIFO    = 3'd5,
    ST_DISCARD = 3'd6
  } seq_state_e;

  // What tx_byte gets loaded with one cycle after a byte is accepted
  typedef enum logic [1:0] {
    LD_NONE   = 2'd0,
    LD_STATUS = 2'd1,
    LD_FILL   = 2'd2,
    LD_FIFO   = 2'd3
  } tx_load_e;

  localparam logic [7:0] CMD_WR_REG  = 8'h01;
  localparam logic [7:0] CMD_RD_REG  = 8'h02;
  localparam logic [7:0] CMD_RD_FIFO = 8'h03;

  localparam int unsigned STAT_FIFO_EMPTY = 7;
  localparam int unsigned STAT_UNDERRUN   = 6;
  localparam int unsigned STAT_ERR        = 5;

  function automatic logic cmd_is_known(input logic [7:0] cmd);
    return (cmd == CMD_WR_REG) || (cmd == CMD_RD_REG) || (cmd == CMD_RD_FIFO);
  endfunction

  function automatic logic [7:0] pack_status(input logic fifo_empty,
                                             input logic underrun,
                                             input logic err);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_FIFO_EMPTY] = fifo_empty;
    s[STAT_UNDERRUN]   = underrun;
    s[STAT_ERR]        = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Bundle between the sequencer and its surroundings: byte shifter side,
// register bus and FWFT read FIFO. master = sequencer, slave = environment.
interface spi_cmd_sequencer_if #(
  parameter int AW = 4
);
  logic          frame_start;
  logic          frame_end;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          busy;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic          fifo_rd_en;
  logic [7:0]    fifo_data;
  logic          fifo_empty;

  modport master (
    input  frame_start, frame_end, rx_valid, rx_byte,
    output tx_byte, tx_valid, busy,
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata,
    output fifo_rd_en,
    input  fifo_data, fifo_empty
  );

  modport slave (
    output frame_start, frame_end, rx_valid, rx_byte,
    input  tx_byte, tx_valid, busy,
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata,
    input  fifo_rd_en,
    output fifo_data, fifo_empty
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Per-frame command decoder behind the SPI slave byte shifter: drives the
// register bus and read FIFO, and prepares the next MISO byte for the shifter.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int         AW        = 4,
  parameter logic [7:0] ID_BYTE   = 8'h3F,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  spi_cmd_sequencer_if.master bus
);

  seq_state_e    state_r, state_s;
  tx_load_e      pend_r, pend_s;
  logic [7:0]    cmd_r, cmd_s;
  logic [7:0]    tx_byte_r, tx_byte_s;
  logic          tx_valid_r, tx_valid_s;
  logic          busy_r, busy_s;
  logic [AW-1:0] reg_addr_r, reg_addr_s;
  logic [7:0]    reg_wdata_r, reg_wdata_s;
  logic          reg_we_r, reg_we_s;
  logic          reg_re_r, reg_re_s;
  logic          rd_cap_r, rd_cap_s;
  logic          fifo_rd_en_r, fifo_rd_en_s;
  logic          underrun_r, underrun_s;
  logic          err_r, err_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, strobe and sticky-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r       <= LD_NONE;
      cmd_r        <= 8'h00;
      tx_byte_r    <= ID_BYTE;
      tx_valid_r   <= 1'b1;
      busy_r       <= 1'b0;
      reg_addr_r   <= {AW{1'b0}};
      reg_wdata_r  <= 8'h00;
      reg_we_r     <= 1'b0;
      reg_re_r     <= 1'b0;
      rd_cap_r     <= 1'b0;
      fifo_rd_en_r <= 1'b0;
      underrun_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      pend_r       <= pend_s;
      cmd_r        <= cmd_s;
      tx_byte_r    <= tx_byte_s;
      tx_valid_r   <= tx_valid_s;
      busy_r       <= busy_s;
      reg_addr_r   <= reg_addr_s;
      reg_wdata_r  <= reg_wdata_s;
      reg_we_r     <= reg_we_s;
      reg_re_r     <= reg_re_s;
      rd_cap_r     <= rd_cap_s;
      fifo_rd_en_r <= fifo_rd_en_s;
      underrun_r   <= underrun_s;
      err_r        <= err_s;
    end
  end

  // Next state, strobes and MISO preparation
  always_comb begin
    state_s      = state_r;
    pend_s       = LD_NONE;
    cmd_s        = cmd_r;
    tx_byte_s    = tx_byte_r;
    tx_valid_s   = tx_valid_r;
    busy_s       = busy_r;
    reg_addr_s   = reg_addr_r;
    reg_wdata_s  = reg_wdata_r;
    reg_we_s     = 1'b0;
    reg_re_s     = 1'b0;
    rd_cap_s     = 1'b0;
    fifo_rd_en_s = 1'b0;
    underrun_s   = underrun_r;
    err_s        = err_r;

    // A committed write always advances the address, even across frame boundaries
    if (reg_we_r) begin
      reg_addr_s = reg_addr_r + AW'(1);
    end else begin
      reg_addr_s = reg_addr_r;
    end

    if (bus.frame_start) begin
      state_s    = ST_CMD;
      busy_s     = 1'b1;
      tx_byte_s  = ID_BYTE;
      tx_valid_s = 1'b1;
    end else begin
      rd_cap_s = reg_re_r;
      if (rd_cap_r) begin
        tx_byte_s  = bus.reg_rdata;
        tx_valid_s = 1'b1;
      end else begin
        case (pend_r)
          LD_STATUS: begin
            tx_byte_s  = pack_status(bus.fifo_empty, underrun_r, err_r);
            tx_valid_s = 1'b1;
            underrun_s = 1'b0;
            err_s      = ~cmd_is_known(cmd_r);
          end
          LD_FILL: begin
            tx_byte_s  = FILL_BYTE;
            tx_valid_s = 1'b1;
          end
          LD_FIFO: begin
            tx_valid_s = 1'b1;
            if (!bus.fifo_empty) begin
              tx_byte_s    = bus.fifo_data;
              fifo_rd_en_s = 1'b1;
            end else begin
              tx_byte_s  = FILL_BYTE;
              underrun_s = 1'b1;
            end
          end
          default: begin
            pend_s = LD_NONE;
          end
        endcase
      end

      if (bus.rx_valid) begin
        case (state_r)
          ST_CMD: begin
            cmd_s      = bus.rx_byte;
            pend_s     = LD_STATUS;
            tx_valid_s = 1'b0;
            state_s    = ST_ADDR;
          end
          ST_ADDR: begin
            tx_valid_s = 1'b0;
            case (cmd_r)
              CMD_WR_REG: begin
                reg_addr_s = bus.rx_byte[AW-1:0];
                pend_s     = LD_FILL;
                state_s    = ST_WR;
              end
              CMD_RD_REG: begin
                reg_addr_s = bus.rx_byte[AW-1:0];
                reg_re_s   = 1'b1;
                state_s    = ST_RD;
              end
              CMD_RD_FIFO: begin
                pend_s  = LD_FIFO;
                state_s = ST_FIFO;
              end
              default: begin
                pend_s  = LD_FILL;
                state_s = ST_DISCARD;
              end
            endcase
          end
          ST_WR: begin
            reg_wdata_s = bus.rx_byte;
            reg_we_s    = 1'b1;
            pend_s      = LD_FILL;
            tx_valid_s  = 1'b0;
          end
          ST_RD: begin
            reg_addr_s = reg_addr_r + AW'(1);
            reg_re_s   = 1'b1;
            tx_valid_s = 1'b0;
          end
          ST_FIFO: begin
            pend_s     = LD_FIFO;
            tx_valid_s = 1'b0;
          end
          default: begin
            pend_s = LD_NONE;
          end
        endcase
      end else begin
        pend_s = LD_NONE;
      end

      // End of frame keeps a same-cycle write but cancels reads, pops and MISO loads
      if (bus.frame_end) begin
        state_s      = ST_IDLE;
        busy_s       = 1'b0;
        tx_byte_s    = ID_BYTE;
        tx_valid_s   = 1'b1;
        pend_s       = LD_NONE;
        rd_cap_s     = 1'b0;
        reg_re_s     = 1'b0;
        fifo_rd_en_s = 1'b0;
        underrun_s   = underrun_r;
        err_s        = err_r;
      end else begin
        busy_s = busy_r;
      end
    end
  end

  assign bus.tx_byte    = tx_byte_r;
  assign bus.tx_valid   = tx_valid_r;
  assign bus.busy       = busy_r;
  assign bus.reg_addr   = reg_addr_r;
  assign bus.reg_wdata  = reg_wdata_r;
  assign bus.reg_we     = reg_we_r;
  assign bus.reg_re     = reg_re_r;
  assign bus.fifo_rd_en = fifo_rd_en_r;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: emulates the byte shifter, a register
// file with one-cycle read latency and a small FWFT FIFO around the sequencer.
module tb_spi_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  spi_cmd_sequencer_if #(.AW(4)) bus ();

  spi_cmd_sequencer #(.AW(4), .ID_BYTE(8'h3F), .FILL_BYTE(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Register file, FIFO and strobe logging
  logic [7:0] regs [16];
  logic [7:0] rdata_q = 8'h00;
  logic [3:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];
  logic [7:0] fifo_mem [8];
  int fifo_wp = 0;
  int fifo_rp = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_pop = 0;

  assign bus.reg_rdata  = rdata_q;
  assign bus.fifo_data  = fifo_mem[fifo_rp[2:0]];
  assign bus.fifo_empty = (fifo_rp == fifo_wp);

  always @(posedge clk) begin
    if (bus.reg_re) begin
      rdata_q <= regs[bus.reg_addr];
      n_rd    <= n_rd + 1;
    end
    if (bus.reg_we) begin
      regs[bus.reg_addr]      <= bus.reg_wdata;
      wr_addr_log[n_wr[3:0]]  <= bus.reg_addr;
      wr_data_log[n_wr[3:0]]  <= bus.reg_wdata;
      n_wr                    <= n_wr + 1;
    end
    if (bus.fifo_rd_en) begin
      fifo_rp <= fifo_rp + 1;
      n_pop   <= n_pop + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_end();
    repeat (3) @(posedge clk);
    #1;
    bus.frame_end = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx();
    int n;
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tx_valid_ready", 32'(bus.tx_valid), 32'd1);
  endtask

  // One byte slot: shifter loads tx_byte, then MOSI byte completes
  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    wait_tx();
    miso = bus.tx_byte;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_byte  = mosi;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m0, m1, m2, m3, m4;
    int wr0, rd0, pop0;

    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_byte",  32'(bus.tx_byte),    32'h3F);
    chk("rst_tx_valid", 32'(bus.tx_valid),   32'd1);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_reg_addr", 32'(bus.reg_addr),   32'd0);
    chk("rst_wdata",    32'(bus.reg_wdata),  32'd0);
    chk("rst_we",       32'(bus.reg_we),     32'd0);
    chk("rst_re",       32'(bus.reg_re),     32'd0);
    chk("rst_pop",      32'(bus.fifo_rd_en), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register write 01 05 AA BB
    pulse_start();
    chk("wr_busy", 32'(bus.busy), 32'd1);
    xfer(8'h01, m0); xfer(8'h05, m1); xfer(8'hAA, m2); xfer(8'hBB, m3);
    pulse_end();
    chk("wr_miso0", 32'(m0), 32'h3F);
    chk("wr_miso1", 32'(m1), 32'h80);
    chk("wr_miso2", 32'(m2), 32'h00);
    chk("wr_miso3", 32'(m3), 32'h00);
    chk("wr_count", 32'(n_wr), 32'd2);
    chk("wr0_addr", 32'(wr_addr_log[0]), 32'h5);
    chk("wr0_data", 32'(wr_data_log[0]), 32'hAA);
    chk("wr1_addr", 32'(wr_addr_log[1]), 32'h6);
    chk("wr1_data", 32'(wr_data_log[1]), 32'hBB);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_tx_byte", 32'(bus.tx_byte), 32'h3F);

    // Preload F=11, 0=22 with a wrapping write burst
    pulse_start();
    xfer(8'h01, m0); xfer(8'h0F, m1); xfer(8'h11, m2); xfer(8'h22, m3);
    pulse_end();
    chk("wrap_wr_addr0", 32'(wr_addr_log[2]), 32'hF);
    chk("wrap_wr_addr1", 32'(wr_addr_log[3]), 32'h0);
    chk("wrap_wr_data1", 32'(wr_data_log[3]), 32'h22);

    // Register read 02 0F with wrap F -> 0
    pulse_start();
    xfer(8'h02, m0); xfer(8'h0F, m1); xfer(8'h00, m2); xfer(8'h00, m3);
    pulse_end();
    chk("rd_miso1", 32'(m1), 32'h80);
    chk("rd_miso2", 32'(m2), 32'h11);
    chk("rd_miso3", 32'(m3), 32'h22);

    // FIFO read with {C1,C2} queued and three data bytes
    fifo_mem[0] = 8'hC1;
    fifo_mem[1] = 8'hC2;
    fifo_wp     = 2;
    pop0 = n_pop;
    pulse_start();
    xfer(8'h03, m0); xfer(8'h99, m1); xfer(8'h00, m2); xfer(8'h00, m3); xfer(8'h00, m4);
    pulse_end();
    chk("fifo_miso1", 32'(m1), 32'h00);
    chk("fifo_miso2", 32'(m2), 32'hC1);
    chk("fifo_miso3", 32'(m3), 32'hC2);
    chk("fifo_miso4", 32'(m4), 32'h00);
    chk("fifo_pops",  32'(n_pop - pop0), 32'd2);

    // Status after underrun shows empty+underrun, then clears
    pulse_start();
    xfer(8'h02, m0); xfer(8'h00, m1);
    pulse_end();
    chk("status_underrun", 32'(m1), 32'hC0);

    // Unknown command: fill bytes only, no strobes
    wr0 = n_wr; rd0 = n_rd; pop0 = n_pop;
    pulse_start();
    xfer(8'h7E, m0); xfer(8'h00, m1); xfer(8'h11, m2); xfer(8'h22, m3);
    pulse_end();
    chk("bad_miso0", 32'(m0), 32'h3F);
    chk("bad_miso1", 32'(m1), 32'h80);
    chk("bad_miso2", 32'(m2), 32'h00);
    chk("bad_miso3", 32'(m3), 32'h00);
    chk("bad_no_wr",  32'(n_wr),  32'(wr0));
    chk("bad_no_rd",  32'(n_rd),  32'(rd0));
    chk("bad_no_pop", 32'(n_pop), 32'(pop0));

    // Abort inside a write data byte: no strobe; err sticky reported
    pulse_start();
    xfer(8'h01, m0); xfer(8'h03, m1);
    pulse_end();
    chk("status_err", 32'(m1), 32'hA0);
    chk("abort_no_wr", 32'(n_wr), 32'd4);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_tx_byte", 32'(bus.tx_byte), 32'h3F);

    // frame_end together with the last rx_valid commits the write
    pulse_start();
    xfer(8'h01, m0); xfer(8'h03, m1);
    wait_tx();
    repeat (4) @(posedge clk);
    #1;
    bus.rx_byte   = 8'h5A;
    bus.rx_valid  = 1'b1;
    bus.frame_end = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid  = 1'b0;
    bus.frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("status_cleared", 32'(m1), 32'h80);
    chk("endrx_wr_count", 32'(n_wr), 32'd5);
    chk("endrx_wr_addr", 32'(wr_addr_log[4]), 32'h3);
    chk("endrx_wr_data", 32'(wr_data_log[4]), 32'h5A);
    chk("endrx_busy", 32'(bus.busy), 32'd0);

    // frame_start with rx_valid: byte dropped, restart at command byte
    pulse_start();
    xfer(8'h01, m0); xfer(8'h07, m1);
    repeat (3) @(posedge clk);
    #1;
    bus.rx_byte     = 8'hDD;
    bus.rx_valid    = 1'b1;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid    = 1'b0;
    bus.frame_start = 1'b0;
    chk("restart_busy", 32'(bus.busy), 32'd1);
    chk("restart_tx_byte", 32'(bus.tx_byte), 32'h3F);
    xfer(8'h01, m0); xfer(8'h08, m1); xfer(8'hCC, m2);
    pulse_end();
    chk("restart_miso0", 32'(m0), 32'h3F);
    chk("restart_wr_count", 32'(n_wr), 32'd6);
    chk("restart_wr_addr", 32'(wr_addr_log[5]), 32'h8);
    chk("restart_wr_data", 32'(wr_data_log[5]), 32'hCC);

    // Asynchronous reset in the middle of a read
    pulse_start();
    xfer(8'h02, m0); xfer(8'h05, m1);
    chk("pre_rst_re", 32'(bus.reg_re), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_re",       32'(bus.reg_re),     32'd0);
    chk("arst_we",       32'(bus.reg_we),     32'd0);
    chk("arst_pop",      32'(bus.fifo_rd_en), 32'd0);
    chk("arst_tx_byte",  32'(bus.tx_byte),    32'h3F);
    chk("arst_tx_valid", 32'(bus.tx_valid),   32'd1);
    chk("arst_busy",     32'(bus.busy),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
